adsr_envelope: RTL

//   Per-voice ADSR amplitude envelope generator, directly upstream of the sine

---
 rtl/adsr_envelope.sv | 108 ++++++++++
 1 files changed

// File: rtl/adsr_envelope.sv
// Per-voice ADSR amplitude envelope. Gate edges pick the phase and sample_tick advances the level.
// The registered level drives the signed amp input of the sine compute stage.
module adsr_envelope #(
    parameter logic [15:0] LEVEL_MAX   = 16'h7FFF,
    parameter bit          RETRIG_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        gate,
    input  logic [15:0] attack_step,
    input  logic [15:0] decay_step,
    input  logic [15:0] sustain_level,
    input  logic [15:0] release_step,
    output logic [15:0] amp,
    output logic [2:0]  env_state,
    output logic        active,
    output logic        done
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] lvl, lvl_nxt;
    logic        gate_d, done_nxt;
    logic        rise, fall;
    logic [15:0] sus_clamped;
    logic [16:0] attack_sum, decay_floor;

    assign rise        = gate & ~gate_d;
    assign fall        = ~gate & gate_d;
    assign sus_clamped = (sustain_level > LEVEL_MAX) ? LEVEL_MAX : sustain_level;
    assign attack_sum  = {1'b0, lvl} + {1'b0, attack_step};
    assign decay_floor = {1'b0, sus_clamped} + {1'b0, decay_step};

    // Gate history keeps sampling during reset so a gate held through reset is not a new note.
    always_ff @(posedge clk) begin
        gate_d <= gate;
        if (reset) begin
            state <= IDLE;
            lvl   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            lvl   <= lvl_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lvl_nxt   = lvl;
        done_nxt  = 1'b0;
        if (rise) begin
            state_nxt = ATTACK;
            lvl_nxt   = RETRIG_ZERO ? 16'h0000 : lvl;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_nxt = RELEASE;
        end else if (sample_tick) begin
            case (state)
                ATTACK: begin
                    if (attack_sum >= {1'b0, LEVEL_MAX}) begin
                        lvl_nxt   = LEVEL_MAX;
                        state_nxt = DECAY;
                    end else begin
                        lvl_nxt = attack_sum[15:0];
                    end
                end
                DECAY: begin
                    // Landing within one step of the sustain target snaps onto it.
                    if (lvl < sus_clamped) begin
                        state_nxt = SUSTAIN;
                    end else if ({1'b0, lvl} <= decay_floor) begin
                        lvl_nxt   = sus_clamped;
                        state_nxt = SUSTAIN;
                    end else begin
                        lvl_nxt = lvl - decay_step;
                    end
                end
                SUSTAIN: lvl_nxt = sus_clamped;
                RELEASE: begin
                    if (lvl <= release_step) begin
                        lvl_nxt   = '0;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        lvl_nxt = lvl - release_step;
                    end
                end
                default: begin
                    lvl_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        amp       = lvl;
        env_state = state;
        active    = (state != IDLE);
    end
endmodule
